// File: rtl/timestamp_unit_pkg.sv
// Shared constants and types for the interrupt time-stamp unit.
// Types are sized for the widest legal configuration; the block narrows
// them to its own parameters.
package timestamp_unit_pkg;

  localparam int TsMaxWidth   = 30;
  localparam int VecMax       = 32;
  localparam int MonoMaxWidth = 32;

  typedef logic [TsMaxWidth-1:0]   TimeStampT;
  typedef logic [MonoMaxWidth-1:0] MonoTimerT;
  typedef logic [VecMax-1:0]       VecT;
  typedef logic [11:0]             CsrAddrT;

  localparam CsrAddrT TimeStampCsrBase = 12'hb40;

  // CSR read-word field positions
  localparam int CsrValidBit = 31;
  localparam int CsrOvrBit   = 30;

endpackage

// File: rtl/timestamp_prescaler.sv
// Prescale counter: counts 0..PreScale and asserts tick in the cycle the
// count equals PreScale, then wraps to 0. PreScale=0 ticks every cycle.
// Ports: clk, rst_n (async, active-low), tick (combinational from count).
module timestamp_prescaler #(
  parameter int unsigned PreScale = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (PreScale > 0) ? $clog2(PreScale + 1) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(PreScale));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/timestamp_unit.sv
// Interrupt time-stamp unit: free-running monotonic timer, prescaled stamp
// counter, and one capture channel per vector latching the stamp on the
// rising edge of its pend line. Captures are read as CSRs at
// CsrBase..CsrBase+VecSize-1 (bit31 valid, bit30 overrun, low bits stamp);
// any write to a channel clears valid/overrun and keeps the stamp.
// Optional macro TIMESTAMP_OVERRUN_EN: a capture on an already-valid channel
// keeps the old stamp and sets overrun instead of overwriting.
// Ports: clk, rst_n (async, active-low), pend_i, csr_addr_i, csr_we_i,
//        csr_hit_o, csr_rdata_o, mono_timer_o, stamp_o.
module timestamp_unit
  import timestamp_unit_pkg::*;
#(
  parameter int      VecSize            = 8,
  parameter int      TimeStampWidth     = 8,
  parameter int      TimeStampPreScaler = 0,
  parameter int      MonoTimerWidth     = 32,
  parameter CsrAddrT CsrBase            = TimeStampCsrBase
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [VecSize-1:0]        pend_i,
  input  logic [11:0]               csr_addr_i,
  input  logic                      csr_we_i,
  output logic                      csr_hit_o,
  output logic [31:0]               csr_rdata_o,
  output logic [MonoTimerWidth-1:0] mono_timer_o,
  output logic [TimeStampWidth-1:0] stamp_o
);

  if (TimeStampWidth < 1 || TimeStampWidth > TsMaxWidth) begin : g_bad_tsw
    $error("timestamp_unit: TimeStampWidth out of range");
  end
  if (VecSize < 1 || VecSize > VecMax) begin : g_bad_vec
    $error("timestamp_unit: VecSize out of range");
  end
  if (MonoTimerWidth < 1 || MonoTimerWidth > MonoMaxWidth) begin : g_bad_mono
    $error("timestamp_unit: MonoTimerWidth out of range");
  end

  logic                                   tick;
  logic [MonoTimerWidth-1:0]              mono_q;
  logic [TimeStampWidth-1:0]              stamp_q;
  logic [VecSize-1:0]                     pend_q, valid_q, cap_ev, clr, keep, ovr;
  logic [VecSize-1:0][TimeStampWidth-1:0] cap_q;
  CsrAddrT                                off;

  timestamp_prescaler #(.PreScale(TimeStampPreScaler)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mono_q  <= '0;
      stamp_q <= '0;
      pend_q  <= '0;
    end else begin
      mono_q  <= mono_q + 1'b1;
      if (tick) stamp_q <= stamp_q + 1'b1;
      pend_q  <= pend_i;
    end
  end

  assign mono_timer_o = mono_q;
  assign stamp_o      = stamp_q;
  assign cap_ev       = pend_i & ~pend_q;

  // Offset only meaningful once the lower bound holds, so no underflow case.
  assign off       = csr_addr_i - CsrBase;
  assign csr_hit_o = (csr_addr_i >= CsrBase) && ({1'b0, off} < 13'(VecSize));

  always_comb begin
    clr = '0;
    for (int v = 0; v < VecSize; v++)
      clr[v] = csr_we_i && csr_hit_o && (off == CsrAddrT'(v));
  end

`ifdef TIMESTAMP_OVERRUN_EN
  // A same-cycle clear lets the new capture through as a fresh one.
  logic [VecSize-1:0] ovr_q;
  assign keep = valid_q & ~clr;
  assign ovr  = ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= '0;
    else begin
      for (int v = 0; v < VecSize; v++) begin
        if (cap_ev[v] && keep[v])     ovr_q[v] <= 1'b1;
        else if (cap_ev[v] || clr[v]) ovr_q[v] <= 1'b0;
      end
    end
  end
`else
  assign keep = '0;
  assign ovr  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cap_q   <= '0;
    end else begin
      for (int v = 0; v < VecSize; v++) begin
        if (cap_ev[v]) begin
          if (!keep[v]) begin
            cap_q[v]   <= stamp_q;
            valid_q[v] <= 1'b1;
          end
        end else if (clr[v]) begin
          valid_q[v] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    for (int v = 0; v < VecSize; v++) begin
      if (csr_hit_o && off == CsrAddrT'(v)) begin
        csr_rdata_o[CsrValidBit]    = valid_q[v];
        csr_rdata_o[CsrOvrBit]      = ovr[v];
        csr_rdata_o[TsMaxWidth-1:0] = TimeStampT'(cap_q[v]);
      end
    end
  end

endmodule

// File: tb/tb_timestamp_unit.sv
module tb_timestamp_unit;

  localparam logic [11:0] BASE = 12'hb40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pend = '0;
  logic [11:0] addr = '0;
  logic        we = 1'b0;
  logic        hit;
  logic [31:0] rdata, mono;
  logic [7:0]  stamp;

  logic [7:0]  ps_pend = '0;
  logic [11:0] ps_addr = BASE;
  logic        ps_we = 1'b0;
  logic        ps_hit;
  logic [31:0] ps_rdata, ps_mono;
  logic [7:0]  ps_stamp;

  int checks = 0, failures = 0;

  timestamp_unit dut (
    .clk(clk), .rst_n(rst_n), .pend_i(pend), .csr_addr_i(addr), .csr_we_i(we),
    .csr_hit_o(hit), .csr_rdata_o(rdata), .mono_timer_o(mono), .stamp_o(stamp)
  );

  timestamp_unit #(.TimeStampPreScaler(3)) dut_ps (
    .clk(clk), .rst_n(rst_n), .pend_i(ps_pend), .csr_addr_i(ps_addr), .csr_we_i(ps_we),
    .csr_hit_o(ps_hit), .csr_rdata_o(ps_rdata), .mono_timer_o(ps_mono), .stamp_o(ps_stamp)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Reference model: cycle count since reset gives the time; each channel
  // holds (valid, overrun, stamp) updated from the rules for edges/clears.
  int unsigned cyc;
  logic [7:0]  prev;
  bit          mv [8];
  bit          mo [8];
  logic [7:0]  ms [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      prev = '0;
      for (int v = 0; v < 8; v++) begin mv[v] = 0; mo[v] = 0; ms[v] = '0; end
    end else begin
      for (int v = 0; v < 8; v++) begin
        bit ev, cl;
        ev = pend[v] && !prev[v];
        cl = we && (addr == BASE + 12'(v));
        if (ev) begin
`ifdef TIMESTAMP_OVERRUN_EN
          if (mv[v] && !cl) mo[v] = 1;
          else begin ms[v] = cyc[7:0]; mv[v] = 1; mo[v] = 0; end
`else
          ms[v] = cyc[7:0]; mv[v] = 1; mo[v] = 0;
`endif
        end else if (cl) begin
          mv[v] = 0; mo[v] = 0;
        end
      end
      prev = pend;
      cyc++;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    int idx;
    if (a < BASE || a >= BASE + 12'd8) return 32'h0;
    idx = int'(a - BASE);
    return {mv[idx], mo[idx], 22'h0, ms[idx]};
  endfunction

  function automatic logic exp_hit(input logic [11:0] a);
    return (a >= BASE) && (a < BASE + 12'd8);
  endfunction

  task automatic wait_stamp(input logic [7:0] v);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cyc[7:0] == v) return;
    end
    checks++; failures++;
    $display("FAIL wait_stamp never reached %h", v);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mono !== 32'h0) begin failures++; $display("FAIL reset_mono got=%h exp=0", mono); end
    checks++; if (stamp !== 8'h0) begin failures++; $display("FAIL reset_stamp got=%h exp=0", stamp); end
    addr = BASE + 12'd3; #1;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (mono !== 32'd10) begin failures++; $display("FAIL idle_mono got=%0d exp=10", mono); end
    checks++; if (stamp !== 8'd10) begin failures++; $display("FAIL idle_stamp got=%0d exp=10", stamp); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ps_stamp !== 8'd3) begin failures++; $display("FAIL ps_stamp_12 got=%0d exp=3", ps_stamp); end
    for (int v = 0; v < 8; v++) begin
      @(negedge clk); addr = BASE + 12'(v); #1;
      checks++;
      if (rdata !== 32'h0 || rdata !== exp_rd(addr))
        begin failures++; $display("FAIL idle_read ch%0d got=%h exp=0", v, rdata); end
    end
  endtask

  task automatic test_prescaler();
    for (int i = 0; i < 2000 && cyc < 1020; i++) @(negedge clk);
    #1;
    checks++; if (ps_stamp !== 8'd255) begin failures++; $display("FAIL ps_stamp_255 got=%0d exp=255", ps_stamp); end
    checks++; if (stamp !== cyc[7:0] || mono !== cyc)
      begin failures++; $display("FAIL timer_track stamp=%h mono=%h exp_cyc=%h", stamp, mono, cyc); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (ps_stamp !== 8'd0) begin failures++; $display("FAIL ps_stamp_wrap got=%0d exp=0", ps_stamp); end
    checks++; if (ps_mono !== cyc) begin failures++; $display("FAIL ps_mono got=%0d exp=%0d", ps_mono, cyc); end
  endtask

  task automatic test_capture();
    logic [31:0] exp2;
    wait_stamp(8'h25);
    pend[2] = 1'b1;
    repeat (5) @(negedge clk);
    addr = BASE + 12'd2; #1;
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL cap_hit got=%b exp=1", hit); end
    checks++; if (rdata !== 32'h8000_0025) begin failures++; $display("FAIL cap_first got=%h exp=80000025", rdata); end
    pend[2] = 1'b0;
    @(negedge clk); pend[2] = 1'b1;
    @(negedge clk); #1;
`ifdef TIMESTAMP_OVERRUN_EN
    exp2 = 32'hC000_0025;
`else
    exp2 = 32'h8000_002B;
`endif
    checks++; if (rdata !== exp2 || rdata !== exp_rd(addr))
      begin failures++; $display("FAIL cap_second got=%h exp=%h", rdata, exp2); end
  endtask

  task automatic test_clear_vs_capture();
    pend[2] = 1'b0;
    wait_stamp(8'h40);
    pend[2] = 1'b1; addr = BASE + 12'd2; we = 1'b1;
    @(negedge clk); we = 1'b0; #1;
    checks++; if (rdata !== 32'h8000_0040) begin failures++; $display("FAIL clr_cap_same got=%h exp=80000040", rdata); end
    we = 1'b1;
    @(negedge clk); we = 1'b0; #1;
    checks++; if (rdata !== 32'h0000_0040) begin failures++; $display("FAIL clear_keep_stamp got=%h exp=00000040", rdata); end
    addr = BASE + 12'd8; we = 1'b1; #1;
    checks++; if (hit !== 1'b0 || rdata !== 32'h0)
      begin failures++; $display("FAIL miss_hi hit=%b rdata=%h exp hit=0 rdata=0", hit, rdata); end
    @(negedge clk); we = 1'b0; addr = BASE - 12'd1; #1;
    checks++; if (hit !== 1'b0 || rdata !== 32'h0)
      begin failures++; $display("FAIL miss_lo hit=%b rdata=%h exp hit=0 rdata=0", hit, rdata); end
  endtask

  task automatic test_simultaneous();
    wait_stamp(8'h11);
    pend[0] = 1'b1; pend[7] = 1'b1;
    @(negedge clk); addr = BASE; #1;
    checks++; if (rdata !== 32'h8000_0011) begin failures++; $display("FAIL simul_ch0 got=%h exp=80000011", rdata); end
    @(negedge clk); addr = BASE + 12'd7; #1;
    checks++; if (rdata !== 32'h8000_0011) begin failures++; $display("FAIL simul_ch7 got=%h exp=80000011", rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      pend = 8'($urandom);
      we   = ($urandom_range(0, 3) == 0);
      addr = BASE - 12'd2 + 12'($urandom_range(0, 11));
      #1;
      checks++;
      if (hit !== exp_hit(addr) || rdata !== exp_rd(addr))
        begin failures++; $display("FAIL random addr=%h hit=%b rdata=%h exp hit=%b rdata=%h",
                                   addr, hit, rdata, exp_hit(addr), exp_rd(addr)); end
    end
    @(negedge clk); we = 1'b0;
  endtask

  task automatic test_reset_hold();
    pend = '0;
    @(negedge clk); pend = 8'h01; addr = BASE;
    @(negedge clk); #1;
    checks++; if (rdata[31] !== 1'b1 || rdata !== exp_rd(addr))
      begin failures++; $display("FAIL pre_reset_valid got=%h exp=%h", rdata, exp_rd(addr)); end
    pend = 8'h02; #1;
    rst_n = 1'b0; #1;
    checks++; if (rdata !== 32'h0 || mono !== 32'h0 || stamp !== 8'h0)
      begin failures++; $display("FAIL async_reset rdata=%h mono=%h stamp=%h exp all 0", rdata, mono, stamp); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk); addr = BASE + 12'd1; #1;
    checks++; if (rdata !== 32'h8000_0000 || rdata !== exp_rd(addr))
      begin failures++; $display("FAIL pend_through_reset got=%h exp=80000000", rdata); end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_capture();
    test_clear_vs_capture();
    test_simultaneous();
    test_random();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timestamp_unit.md
# timestamp_unit

Parametrised interrupt time-stamp unit for the N-CLIC interrupt controller. It runs a free-running monotonic timer and a prescaled time-stamp counter. On each rising edge of a vector's pend line it captures the current time stamp into that vector's register. All captures are exposed as read-only CSRs at a configurable base address, with write-to-clear. The unit sits beside the N-CLIC and feeds the CSR read mux. It extends the fixed single-width time-stamp configuration to parametric vector count, stamp width and prescaler.

## Interface
- VecSize, 8, number of interrupt vectors and capture channels (1..32)
- TimeStampWidth, 8, width of the prescaled stamp counter and of each capture (1..30)
- TimeStampPreScaler, 0, the stamp counter advances once every TimeStampPreScaler+1 cycles
- MonoTimerWidth, 32, width of the monotonic timer (1..32)
- CsrBase, 'hb40, 12-bit CSR address of channel 0's capture register
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low)
- pend_i  in  VecSize  per-vector pend level from the N-CLIC
- csr_addr_i  in  12  CSR address
- csr_we_i  in  1  CSR write strobe; the write data is ignored
- csr_hit_o  out  1  csr_addr_i falls within CsrBase..CsrBase+VecSize-1 (combinational)
- csr_rdata_o  out  32  read data for the addressed channel (combinational), 0 when there is no hit
- mono_timer_o  out  MonoTimerWidth  monotonic timer value
- stamp_o  out  TimeStampWidth  current stamp counter value

## Operation
- Monotonic timer: increments by 1 every cycle and wraps from all-ones to 0.
- Prescaler: counts 0..TimeStampPreScaler. When it equals TimeStampPreScaler it produces a tick and returns to 0. With TimeStampPreScaler=0, every cycle is a tick.
- Stamp counter: increments by 1 on each tick and wraps modulo 2^TimeStampWidth.
- Edge detect: the unit keeps a one-cycle-delayed copy pend_q of pend_i. A capture event for vector v occurs when pend_i[v]=1 and pend_q[v]=0.
- On a capture event, channel v latches the current stamp_o value and sets valid[v]=1.
- CSR read layout per channel:
  - bit 31: valid
  - bit 30: overrun (0 when the overrun feature is compiled out)
  - bits TimeStampWidth-1:0: the captured stamp
  - all other bits: 0
- CSR write (csr_we_i=1 with a hit) to channel v clears valid[v] and overrun[v]. The stamp value is retained.
- A write that does not hit is ignored.
- Capture and clear on the same channel in the same cycle: the capture wins. The result is valid=1, the new stamp, overrun=0.
- Events on different channels in the same cycle are independent. Any number of channels may capture in one cycle.

## Timing
- Reset values: mono_timer_o=0, stamp_o=0, prescaler=0, pend_q=0, and all stamp/valid/overrun bits 0. csr_rdata_o is therefore 0 for any address.
- Because pend_q resets to 0, a pend_i line already high when reset deasserts produces a capture on the first clock edge.
- Capture latency: if the edge is present in cycle n, the CSR reads valid with the stamp value of cycle n from cycle n+1 onward.
- The stamp value of cycle n is the value before that edge's tick increment.
- Clear latency: a write in cycle n reads as cleared from cycle n+1.
- CSR reads are combinational within the same cycle and have no side effects.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous). Any capture in that cycle is lost.

## Configuration
- TIMESTAMP_OVERRUN_EN defined:
  - A capture event on a channel with valid=1 keeps the existing stamp and sets overrun=1.
  - Clearing resets both valid and overrun.
- TIMESTAMP_OVERRUN_EN undefined:
  - Every capture event overwrites the stamp.
  - Bit 30 reads 0 and no overrun storage is synthesised.

## Structure
- Shared package constants and types: TimeStampT, MonoTimerT, VecT, the CSR address type, TimeStampCsrBase, and the field positions for bits 31 and 30.
- Parameter legality (TimeStampWidth<=30, VecSize<=32) is enforced by elaboration-time assertions in the block.
- One sub-module, timestamp_prescaler: the prescale counter and tick generation, reused by other timer blocks.

## Test plan
- Reset, then idle 10 cycles with TimeStampPreScaler=0 → mono_timer_o=10, stamp_o=10, all channel reads 'h0000_0000.
- TimeStampPreScaler=3: 12 cycles after reset → stamp_o=3. With TimeStampWidth=8, run to stamp 255, then 4 more cycles → stamp_o=0.
- PreScaler=0: raise pend_i[2] when stamp_o='h25 and hold it high 5 cycles → read at CsrBase+2 = 'h8000_0025. A second edge without clear: 'h8000_0025 plus bit 30 (='hC000_0025) with TIMESTAMP_OVERRUN_EN, or the new stamp without it.
- Write to CsrBase+2 in the same cycle as a new edge on pend_i[2] at stamp 'h40 → read 'h8000_0040.
- Simultaneous edges on pend_i[0] and pend_i[7] at stamp 'h11 → both channels read 'h8000_0011. Address CsrBase+8 → csr_hit_o=0, csr_rdata_o=0.
- Hold pend_i[1]=1 through reset release → channel 1 valid with stamp 0. Assert rst_n mid-run → all reads return 0 immediately.
